// File: rtl/spad_bank_array.sv
// Multi-bank scratchpad with byte write enables, wired-OR active-low read bus
// and a hardware clear sequencer. Define SPAD_BYPASS_EN for same-edge write-to-read forwarding.
module spad_bank_array #(
    parameter int WIDTH = 32,
    parameter int AW    = 4,
    parameter int BANKS = 2,
    localparam int BW   = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic               clk,
    input  logic               rst_l,
    input  logic [AW-1:0]      wspa_h,
    input  logic [BW-1:0]      wbank_h,
    input  logic [WIDTH-1:0]   wbus_h,
    input  logic [WIDTH/8-1:0] spw_l,
    input  logic [AW-1:0]      mspa_h,
    input  logic [BANKS-1:0]   mcs_l,
    output logic [WIDTH-1:0]   mbus_l,
    output logic               mbus_oe_h,
    input  logic               clr_req_h,
    output logic               clr_busy_h
);

    localparam int NBYTES = WIDTH / 8;
    localparam logic [BW:0] BANKS_LIM = (BW + 1)'(BANKS);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t            r_state;
    state_t            w_stateNext;
    logic [AW-1:0]     r_clrAddr;
    logic [AW-1:0]     w_clrAddrNext;
    logic              w_busy;
    logic              w_wrValid;
    logic [WIDTH-1:0]  r_mem [BANKS][2**AW];
    logic [WIDTH-1:0]  w_bankWord [BANKS];
    logic [WIDTH-1:0]  w_readData;
    logic              w_anySel;
    logic [WIDTH-1:0]  r_mbus;
    logic              r_oe;

    assign w_busy    = (r_state == ST_CLEAR);
    assign w_wrValid = !w_busy && ({1'b0, wbank_h} < BANKS_LIM);
    assign w_anySel  = ~&mcs_l;

    // Reset lands in CLEAR so the array is always initialised before use.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state   <= ST_CLEAR;
            r_clrAddr <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_clrAddr <= w_clrAddrNext;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_clrAddrNext = r_clrAddr;
        case (r_state)
            ST_IDLE: begin
                if (clr_req_h) begin
                    w_stateNext   = ST_CLEAR;
                    w_clrAddrNext = '0;
                end
            end
            ST_CLEAR: begin
                w_clrAddrNext = r_clrAddr + 1'b1;
                if (&r_clrAddr) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    // Storage has no reset; only the clear sequencer initialises it.
    always_ff @(posedge clk) begin
        if (w_busy) begin
            for (int b = 0; b < BANKS; b++) begin
                r_mem[b][r_clrAddr] <= '0;
            end
        end else if (w_wrValid) begin
            for (int b = 0; b < BANKS; b++) begin
                if (wbank_h == BW'(b)) begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (!spw_l[i]) begin
                            r_mem[b][wspa_h][8*i +: 8] <= wbus_h[8*i +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        w_readData = '1;
        for (int b = 0; b < BANKS; b++) begin
            w_bankWord[b] = r_mem[b][mspa_h];
`ifdef SPAD_BYPASS_EN
            if (w_busy && (mspa_h == r_clrAddr)) begin
                w_bankWord[b] = '0;
            end else if (w_wrValid && (wbank_h == BW'(b)) && (wspa_h == mspa_h)) begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (!spw_l[i]) begin
                        w_bankWord[b][8*i +: 8] = wbus_h[8*i +: 8];
                    end
                end
            end
`endif
            if (!mcs_l[b]) begin
                w_readData = w_readData & ~w_bankWord[b];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_mbus <= '1;
            r_oe   <= 1'b0;
        end else begin
            r_mbus <= w_readData;
            r_oe   <= w_anySel;
        end
    end

    assign mbus_l     = r_mbus;
    assign mbus_oe_h  = r_oe;
    assign clr_busy_h = w_busy;

endmodule

// File: tb/tb_spad_bank_array.sv
// Randomised bench for spad_bank_array against an array-based reference model;
// honours SPAD_BYPASS_EN the same way the design does.
module tb_spad_bank_array;

    localparam int WIDTH = 32;
    localparam int AW    = 4;
    localparam int BANKS = 2;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_l;
    logic [3:0]  wspa_h;
    logic [0:0]  wbank_h;
    logic [31:0] wbus_h;
    logic [3:0]  spw_l;
    logic [3:0]  mspa_h;
    logic [1:0]  mcs_l;
    logic [31:0] mbus_l;
    logic        mbus_oe_h;
    logic        clr_req_h;
    logic        clr_busy_h;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [BANKS][DEPTH];
    int          clrLeft;
    int          clrPtr;
    logic [31:0] expBus;
    logic        expOe;

    spad_bank_array #(.WIDTH(WIDTH), .AW(AW), .BANKS(BANKS)) dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .wspa_h    (wspa_h),
        .wbank_h   (wbank_h),
        .wbus_h    (wbus_h),
        .spw_l     (spw_l),
        .mspa_h    (mspa_h),
        .mcs_l     (mcs_l),
        .mbus_l    (mbus_l),
        .mbus_oe_h (mbus_oe_h),
        .clr_req_h (clr_req_h),
        .clr_busy_h(clr_busy_h)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [0:0] wb, input logic [3:0] wa, input logic [31:0] wd,
                                 input logic [3:0] sw, input logic [3:0] ra, input logic [1:0] cs,
                                 input logic cr);
        wbank_h   = wb;
        wspa_h    = wa;
        wbus_h    = wd;
        spw_l     = sw;
        mspa_h    = ra;
        mcs_l     = cs;
        clr_req_h = cr;
    endtask

    // Word a selected bank drives onto the bus at this edge.
    function automatic logic [31:0] bankWord(input int b);
        logic [31:0] w;
        w = model[b][mspa_h];
`ifdef SPAD_BYPASS_EN
        if (clrLeft > 0 && clrPtr == int'(mspa_h)) begin
            w = '0;
        end else if (clrLeft == 0 && int'(wbank_h) == b && wspa_h == mspa_h) begin
            for (int i = 0; i < 4; i++) begin
                if (!spw_l[i]) w[8*i +: 8] = wbus_h[8*i +: 8];
            end
        end
`endif
        return w;
    endfunction

    task automatic stepCycle();
        expBus = 32'hFFFF_FFFF;
        for (int b = 0; b < BANKS; b++) begin
            if (!mcs_l[b]) expBus = expBus & ~bankWord(b);
        end
        expOe = (mcs_l != 2'b11);
        if (clrLeft > 0) begin
            for (int b = 0; b < BANKS; b++) model[b][clrPtr] = '0;
            clrPtr++;
            clrLeft--;
        end else begin
            if (clr_req_h) begin
                clrLeft = DEPTH;
                clrPtr  = 0;
            end
            if (int'(wbank_h) < BANKS) begin
                for (int i = 0; i < 4; i++) begin
                    if (!spw_l[i]) model[wbank_h][wspa_h][8*i +: 8] = wbus_h[8*i +: 8];
                end
            end
        end
        @(posedge clk);
        #1;
        checkOutput("mbus", mbus_l, expBus);
        checkOutput("oe", {31'b0, mbus_oe_h}, {31'b0, expOe});
        checkOutput("busy", {31'b0, clr_busy_h}, {31'b0, (clrLeft > 0)});
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int busyCnt;
        logic [3:0] wa;
        logic [3:0] ra;

        rst_l = 1'b0;
        applyStimulus(1'b0, 4'h0, 32'h0, 4'hF, 4'h0, 2'b11, 1'b0);
        clrLeft = DEPTH;
        clrPtr  = 0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstBus", mbus_l, 32'hFFFF_FFFF);
        checkOutput("rstOe", {31'b0, mbus_oe_h}, 32'h0);
        checkOutput("rstBusy", {31'b0, clr_busy_h}, 32'h1);
        rst_l = 1'b1;
        for (int k = 0; k < DEPTH; k++) stepCycle();
        checkOutput("initDone", {31'b0, clr_busy_h}, 32'h0);

        applyStimulus(1'b0, 4'h0, 32'h0, 4'hF, 4'd5, 2'b10, 1'b0);
        stepCycle();
        checkOutput("rdZero", mbus_l, 32'hFFFF_FFFF);
        checkOutput("rdZeroOe", {31'b0, mbus_oe_h}, 32'h1);

        applyStimulus(1'b1, 4'd3, 32'h1234_5678, 4'b0000, 4'd0, 2'b11, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 4'd3, 32'hAABB_CCDD, 4'b1010, 4'd0, 2'b11, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 4'd0, 32'h0, 4'hF, 4'd3, 2'b01, 1'b0);
        stepCycle();
        checkOutput("byteWr", mbus_l, ~32'h12BB_56DD);

        applyStimulus(1'b0, 4'd7, 32'h0000_FF00, 4'b0000, 4'd0, 2'b11, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 4'd7, 32'h0000_00F0, 4'b0000, 4'd0, 2'b11, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 4'd0, 32'h0, 4'hF, 4'd7, 2'b00, 1'b0);
        stepCycle();
        checkOutput("multiRd", mbus_l, ~32'h0000_FFF0);
        applyStimulus(1'b0, 4'd0, 32'h0, 4'hF, 4'd7, 2'b11, 1'b0);
        stepCycle();
        checkOutput("noSel", mbus_l, 32'hFFFF_FFFF);
        checkOutput("noSelOe", {31'b0, mbus_oe_h}, 32'h0);

        applyStimulus(1'b0, 4'd2, 32'h1111_1111, 4'b0000, 4'd0, 2'b11, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 4'd2, 32'h2222_2222, 4'b0000, 4'd2, 2'b10, 1'b0);
        stepCycle();
`ifdef SPAD_BYPASS_EN
        checkOutput("sameEdge", mbus_l, ~32'h2222_2222);
`else
        checkOutput("sameEdge", mbus_l, ~32'h1111_1111);
`endif

        for (int k = 0; k < 300; k++) begin
            wa = 4'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom);
            applyStimulus(1'($urandom), wa, $urandom, 4'($urandom), ra, 2'($urandom),
                          ($urandom_range(0, 39) == 0));
            stepCycle();
        end
        while (clrLeft > 0) begin
            applyStimulus(1'b0, 4'h0, 32'h0, 4'hF, 4'h0, 2'b11, 1'b0);
            stepCycle();
        end

        for (int b = 0; b < BANKS; b++) begin
            for (int a = 0; a < DEPTH; a++) begin
                applyStimulus(1'(b), 4'(a), 32'hFFFF_FFFF, 4'b0000, 4'h0, 2'b11, 1'b0);
                stepCycle();
            end
        end
        applyStimulus(1'b0, 4'h0, 32'h0, 4'hF, 4'h0, 2'b11, 1'b1);
        stepCycle();
        busyCnt = clr_busy_h ? 1 : 0;
        for (int k = 0; k < 40 && clr_busy_h; k++) begin
            applyStimulus(1'(k), 4'(k), 32'hDEAD_BEEF, 4'b0000, 4'(k + 3), 2'b11, 1'b0);
            stepCycle();
            if (clr_busy_h) busyCnt++;
        end
        checkOutput("busyLen", busyCnt, 32'd16);
        for (int b = 0; b < BANKS; b++) begin
            for (int a = 0; a < DEPTH; a++) begin
                applyStimulus(1'b0, 4'h0, 32'h0, 4'hF, 4'(a), (b == 0) ? 2'b10 : 2'b01, 1'b0);
                stepCycle();
                checkOutput("clrRd", mbus_l, 32'hFFFF_FFFF);
            end
        end

        applyStimulus(1'b0, 4'h0, 32'h0, 4'hF, 4'h0, 2'b11, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 4'h0, 32'h0, 4'hF, 4'h0, 2'b11, 1'b0);
        for (int k = 0; k < 9; k++) stepCycle();
        rst_l = 1'b0;
        #1;
        checkOutput("midRstBusy", {31'b0, clr_busy_h}, 32'h1);
        checkOutput("midRstBus", mbus_l, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        rst_l   = 1'b1;
        clrLeft = DEPTH;
        clrPtr  = 0;
        busyCnt = 0;
        for (int k = 0; k < 40 && clr_busy_h; k++) begin
            stepCycle();
            busyCnt++;
        end
        checkOutput("restartLen", busyCnt, 32'd16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
